tube_arbiter: RTL and testbench
===============================

# tube_arbiter

Shares the single seven-segment tube driver between up to `N_REQ` display requesters: the CPU MMIO write port, debug register tap, switch echo, and similar sources. Requesters are granted in round-robin order. Each grant keeps the display for a minimum dwell time, so a value stays readable before the next owner takes over. The block sits between the requesters and the tube driver's `reg_data` input, and drives that input from `disp_data`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DWELL`, default `` `TUBE_DWELL `` (100_000_000, i.e. 1 s at 100 MHz): minimum clk cycles an owner holds the display, ≥1.
- `clk` input 1: 100 MHz system clock.
- `reset` input 1: asynchronous, active-low reset.
- `req` input N_REQ: per-requester display request, level.
- `req_data` input 32·N_REQ: requester i's value in bits [32i+31:32i].
- `gnt` output N_REQ: one-cycle one-hot pulse marking the start of a new grant.
- `disp_owner` output 3: index of the current owner; only bits [$clog2(N_REQ)-1:0] are meaningful, the rest are 0.
- `disp_valid` output 1: high once any requester has ever been granted.
- `disp_data` output 32: value to the tube driver.

## Operation
- States:
  - IDLE: no owner.
  - HOLD: owner present, dwell counter running.
  - OPEN: dwell expired, display still held by the owner.
- IDLE → HOLD: any `req` high. Winner is chosen by the round-robin pick starting at index `rr_ptr+1` (mod N_REQ).
- On entering HOLD:
  - `disp_owner`←winner, `gnt[winner]` pulses.
  - Dwell counter loads DWELL-1.
  - `rr_ptr`←winner, `disp_valid`←1.
- HOLD: the counter decrements every cycle. When the counter is 0 the state moves to OPEN. Other requests are ignored.
- OPEN, when any non-owner `req` is high: grant the next non-owner in round-robin order and re-enter HOLD. The owner's own `req` does not block rotation.
- OPEN, when only the owner, or nobody, requests: stay in OPEN with no new `gnt` pulse. The block never returns to IDLE except through reset.
- `disp_data` update rule (HOLD and OPEN):
  - Each cycle the owner's `req` is high, `disp_data`←owner's `req_data` (live tracking).
  - When the owner's `req` is low, `disp_data` holds its last value.
- Dropping `req` during HOLD does not shorten the dwell.
- Counter width is $clog2(DWELL+1), and the counter never wraps below 0.
- Reset values:
  - `gnt`=0, `disp_owner`=0, `disp_valid`=0, `disp_data`=0.
  - State IDLE, `rr_ptr`=N_REQ-1, so requester 0 wins first.

## Timing
- All outputs are registered. `req` and `req_data` are sampled on the rising clk edge.
- Grant latency: `req` high at edge k gives `gnt`, `disp_owner` and `disp_data` updated after edge k (visible in cycle k+1).
- Rotation occurs no earlier than DWELL cycles after the grant edge.
- Live data latency is 1 cycle.
- When the dwell expires and another request is already pending: with DWELL=N, grant edges are spaced exactly N+1 cycles apart (N HOLD cycles plus one OPEN cycle).
- Reset asserted mid-grant clears everything immediately and asynchronously. After release, the first `req` edge is a fresh IDLE grant.

## Configuration
- `TUBE_ARB_PRIO_EN` defined: requester 0 is urgent.
  - `req[0]` rising while a different owner is in HOLD or OPEN preempts on the next edge.
  - The preemption pulses `gnt[0]` and reloads the dwell.
  - `rr_ptr` is not updated by the preemption.
- `TUBE_ARB_PRIO_EN` undefined: requester 0 is a plain round-robin member and there is no preemption logic.

## Structure
- In `parameters.v`: add `` `TUBE_DWELL `` and the state encodings `` `TARB_IDLE ``, `` `TARB_HOLD `` and `` `TARB_OPEN ``.
- One sub-module, `tube_rr_pick`: combinational round-robin picker.
  - Inputs: request mask and start pointer.
  - Outputs: one-hot winner, encoded index and any-hit.
  - Instantiated once, with the current owner masked out in OPEN.

## Test plan
All scenarios use DWELL=4, N_REQ=4.
- Reset then `req`=4'b0110: `gnt`=4'b0010 one cycle later. `disp_owner`=1, `disp_data`=req1 data, `disp_valid`=1.
- Continue holding `req`=4'b0110: `gnt`=4'b0100 exactly 5 cycles after the first grant. Requester 1 is then regranted 5 cycles after that.
- Owner 2 alone, `req_data2` changing 0x1234→0xABCD mid-HOLD: `disp_data` follows with 1-cycle latency. Drop `req2`: `disp_data` stays 0xABCD, and there is no further `gnt` while `req`=0.
- Owner drops `req` one cycle after its grant while `req3` is raised: `disp_owner` does not change until 5 cycles after the grant, then `gnt`=4'b1000.
- Assert `reset` low during HOLD: all outputs are 0 within the same cycle. After release with `req`=4'b1111, requester 0 is granted first.
- With `TUBE_ARB_PRIO_EN`, owner 2 in HOLD and `req0` rising: `gnt`=4'b0001 on the next edge. The next rotation after requester 0's dwell goes to requester 3.

Source files
------------

// File: rtl/tube_arbiter_pkg.sv
// Shared definitions for the seven-segment tube arbiter: dwell default and state encodings.
// Optional urgent-requester-0 preemption is enabled with `TUBE_ARB_PRIO_EN.
`ifndef TUBE_DWELL
`define TUBE_DWELL 100_000_000
`endif
`ifndef TARB_IDLE
`define TARB_IDLE 2'd0
`endif
`ifndef TARB_HOLD
`define TARB_HOLD 2'd1
`endif
`ifndef TARB_OPEN
`define TARB_OPEN 2'd2
`endif

package tube_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = `TARB_IDLE,
    S_HOLD = `TARB_HOLD,
    S_OPEN = `TARB_OPEN
  } tarb_state_e;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic logic [2:0] rr_next(input logic [2:0] p, input int n);
    return (int'(p) == n - 1) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/tube_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after 'start', wrapping.
module tube_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] mask,
  input  logic [2:0]       start,
  output logic [N_REQ-1:0] onehot,
  output logic [2:0]       idx,
  output logic             hit
);

  logic [N_REQ-1:0] rot;
  logic [3:0]       sum;

  // Rotate so that bit 0 corresponds to 'start'; then a priority scan from bit 0.
  assign rot = N_REQ'({mask, mask} >> start);

  always_comb begin
    hit = 1'b0;
    sum = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!hit && rot[j]) begin
        hit = 1'b1;
        sum = {1'b0, start} + 4'(j);
      end
    end
    if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
    idx    = sum[2:0];
    onehot = hit ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/tube_arbiter.sv
// Round-robin owner of the tube driver with a minimum dwell per grant.
// Define `TUBE_ARB_PRIO_EN to let a rising req[0] preempt any other owner.
`ifndef TUBE_DWELL
`define TUBE_DWELL 100_000_000
`endif
module tube_arbiter
  import tube_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DWELL = `TUBE_DWELL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      gnt,
  output logic [2:0]            disp_owner,
  output logic                  disp_valid,
  output logic [31:0]           disp_data
);

  localparam int CW = $clog2(DWELL + 1);
  localparam int IW = $clog2(N_REQ);
  localparam logic [CW-1:0] DWELL_M1 = CW'(DWELL - 1);

  tarb_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       rr_q, rr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [31:0]      data_q, data_d;

  logic [31:0]      dat [N_REQ];
  logic [N_REQ-1:0] own_oh, pk_mask, pk_oh;
  logic [2:0]       pk_start, pk_idx;
  logic             pk_hit, grant, pre;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) dat[i] = req_data[32*i +: 32];
  end

  // In OPEN the owner is masked out so its own request never blocks rotation.
  assign own_oh   = N_REQ'(1) << owner_q;
  assign pk_mask  = (state_q == S_OPEN) ? (req & ~own_oh) : req;
  assign pk_start = rr_next(rr_q, N_REQ);

  tube_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .mask   (pk_mask),
    .start  (pk_start),
    .onehot (pk_oh),
    .idx    (pk_idx),
    .hit    (pk_hit)
  );

`ifdef TUBE_ARB_PRIO_EN
  logic req0_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) req0_q <= 1'b0;
    else        req0_q <= req[0];
  end
  assign pre = (state_q != S_IDLE) && (owner_q != 3'd0) && req[0] && !req0_q;
`else
  assign pre = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    valid_d = valid_q;
    data_d  = data_q;
    grant   = 1'b0;
    if (state_q != S_IDLE && req[owner_q[IW-1:0]]) data_d = dat[owner_q[IW-1:0]];
    case (state_q)
      S_IDLE: grant = pk_hit;
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_OPEN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_OPEN: grant = pk_hit;
      default: state_d = S_IDLE;
    endcase
    // Preemption restarts the dwell but leaves the rotation pointer alone.
    if (pre) begin
      state_d = S_HOLD;
      cnt_d   = DWELL_M1;
      owner_d = 3'd0;
      gnt_d   = N_REQ'(1);
      data_d  = dat[0];
    end else if (grant) begin
      state_d = S_HOLD;
      cnt_d   = DWELL_M1;
      owner_d = pk_idx;
      rr_d    = pk_idx;
      gnt_d   = pk_oh;
      valid_d = 1'b1;
      data_d  = dat[pk_idx[IW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= 3'd0;
      rr_q    <= 3'(N_REQ - 1);
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign gnt        = gnt_q;
  assign disp_owner = owner_q;
  assign disp_valid = valid_q;
  assign disp_data  = data_q;

endmodule

// File: tb/tb_tube_arbiter.sv
// Directed and randomized checks of tube_arbiter (N_REQ=4, DWELL=4) against a grant-age reference model.
module tb_tube_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   gnt;
  logic [2:0]   disp_owner;
  logic         disp_valid;
  logic [31:0]  disp_data;

  tube_arbiter #(.N_REQ(N), .DWELL(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .disp_owner (disp_owner),
    .disp_valid (disp_valid),
    .disp_data  (disp_data)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Reference model: owner, rotation pointer, and the edge number of the last grant.
  bit          m_started;
  int          m_owner, m_rr, m_edge, m_gtime;
  logic [3:0]  m_gnt;
  logic [31:0] m_data;
  bit          m_prev0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int pick(input int s, input logic [3:0] m);
    for (int k = 0; k < N; k++) if (m[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  task automatic model_reset();
    m_started = 0; m_owner = 0; m_rr = N - 1; m_gtime = 0;
    m_gnt = '0; m_data = '0; m_prev0 = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [127:0] d);
    int  win;
    bit  pre;
    logic [3:0] msk;
    m_edge++;
    m_gnt = '0;
    win = -1;
    pre = 0;
    if (!m_started) win = pick((m_rr + 1) % N, r);
    else begin
`ifdef TUBE_ARB_PRIO_EN
      if (r[0] && !m_prev0 && m_owner != 0) begin win = 0; pre = 1; end
`endif
      if (!pre && (m_edge - m_gtime) > DW) begin
        msk = r & ~(4'b0001 << m_owner);
        win = pick((m_rr + 1) % N, msk);
      end
    end
    if (win >= 0) begin
      m_owner = win;
      m_gnt = 4'b0001 << win;
      m_gtime = m_edge;
      if (!pre) m_rr = win;
      m_started = 1;
      m_data = d[32*win +: 32];
    end else if (m_started && r[m_owner]) begin
      m_data = d[32*m_owner +: 32];
    end
    m_prev0 = r[0];
  endtask

  task automatic cyc(input logic [3:0] r, input logic [127:0] d);
    req = r;
    req_data = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    chk("m_gnt",   32'(gnt),        32'(m_gnt));
    chk("m_owner", 32'(disp_owner), 32'(m_owner));
    chk("m_valid", 32'(disp_valid), 32'(m_started));
    chk("m_data",  disp_data,       m_data);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("rst_gnt",   32'(gnt),        32'h0);
    chk("rst_owner", 32'(disp_owner), 32'h0);
    chk("rst_valid", 32'(disp_valid), 32'h0);
    chk("rst_data",  disp_data,       32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  logic [127:0] d1, dr;
  logic [3:0]   rr;

  initial begin
    m_edge = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_gnt",   32'(gnt),        32'h0);
    chk("por_owner", 32'(disp_owner), 32'h0);
    chk("por_valid", 32'(disp_valid), 32'h0);
    chk("por_data",  disp_data,       32'h0);
    reset = 1'b1;

    // First grant from IDLE with req=0110 goes to requester 1.
    d1 = pack4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    cyc(4'b0110, d1);
    chk("g1_gnt",   32'(gnt),        32'h2);
    chk("g1_owner", 32'(disp_owner), 32'h1);
    chk("g1_data",  disp_data,       32'h22222222);
    chk("g1_valid", 32'(disp_valid), 32'h1);

    // Rotation spacing DWELL+1 with a pending competitor.
    for (int i = 1; i <= 5; i++) begin
      cyc(4'b0110, d1);
      chk("rot_to2", 32'(gnt), (i == 5) ? 32'h4 : 32'h0);
    end
    for (int i = 1; i <= 5; i++) begin
      cyc(4'b0110, d1);
      chk("rot_to1", 32'(gnt), (i == 5) ? 32'h2 : 32'h0);
    end

    // Live data tracking, then hold after the owner drops.
    do_reset();
    cyc(4'b0100, pack4(0, 0, 32'h1234, 0));
    chk("live_gnt",  32'(gnt), 32'h4);
    chk("live_d0",   disp_data, 32'h1234);
    cyc(4'b0100, pack4(0, 0, 32'hABCD, 0));
    chk("live_d1",   disp_data, 32'hABCD);
    for (int i = 0; i < 7; i++) begin
      cyc(4'b0000, pack4(0, 0, 32'h5555, 0));
      chk("hold_data", disp_data, 32'hABCD);
      chk("hold_gnt",  32'(gnt),  32'h0);
    end

    // Owner drops right after grant; dwell still runs to completion.
    do_reset();
    cyc(4'b0001, d1);
    for (int i = 1; i <= 5; i++) begin
      cyc(4'b1000, d1);
      chk("drop_owner", 32'(disp_owner), (i == 5) ? 32'h3 : 32'h0);
      chk("drop_gnt",   32'(gnt),        (i == 5) ? 32'h8 : 32'h0);
    end

    // Reset mid-HOLD, then all request: requester 0 first.
    do_reset();
    cyc(4'b0001, d1);
    cyc(4'b0001, d1);
    do_reset();
    cyc(4'b1111, d1);
    chk("post_rst_gnt", 32'(gnt), 32'h1);

`ifdef TUBE_ARB_PRIO_EN
    do_reset();
    cyc(4'b0100, d1);
    cyc(4'b1101, d1);
    chk("prio_gnt", 32'(gnt), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      cyc(4'b1101, d1);
      chk("prio_next", 32'(gnt), (i == 5) ? 32'h8 : 32'h0);
    end
`endif

    // Randomized traffic with sticky request patterns.
    do_reset();
    rr = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      dr = {$urandom, $urandom, $urandom, $urandom};
      cyc(rr, dr);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
